// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt-acknowledge path: handshake states,
// spurious level code and vector field widths.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } inta_state_e;

  localparam int LEVEL_W  = 3;
  localparam int BASE_W   = 5;
  localparam int VECTOR_W = 8;

  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  function automatic logic [VECTOR_W-1:0] make_vector(input logic [BASE_W-1:0]  base,
                                                      input logic [LEVEL_W-1:0] level);
    return {base, level};
  endfunction

endpackage

// File: rtl/inta_sync_edge.sv
// Multi-flop synchronizer for an asynchronous active-low strobe, with fall/rise
// detection on the synchronized stream. All flops reset to the inactive (high) level.
module inta_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   level_s;

  assign level_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain plus one-cycle history of the synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '1;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= level_s;
    end
  end

  assign fall = prev_r & ~level_s;
  assign rise = ~prev_r & level_s;

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode two-pulse INTA_N sequencer: latches the granted level, drives the
// cascade handshake and presents the vector on the data bus during the second pulse.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                INTA_N,
  input  logic                SNGL,
  input  logic                Master_Slave,
  input  logic [2:0]          ID,
  input  logic [2:0]          SLAVE_ID,
  input  logic [7:0]          SLAVE_MASK,
  input  logic                AEOI,
  input  logic [4:0]          VECTOR_BASE,
  input  logic                INT_PENDING,
  input  logic [2:0]          INT_LEVEL,
  output logic                INT,
  output logic                INTA_2,
  output logic [2:0]          ISR,
  output logic                ISR_SET,
  output logic                AEOI_CLR,
  output logic [7:0]          D_OUT,
  output logic                D_OE
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic fall_s, rise_s;

  inta_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (INTA_N),
    .fall     (fall_s),
    .rise     (rise_s)
  );

  inta_state_e          state_r, state_s;
  logic                 int_r, int_s;
  logic                 inta2_r, inta2_s;
  logic [LEVEL_W-1:0]   isr_r, isr_s;
  logic                 isr_set_r, isr_set_s;
  logic                 aeoi_pend_r, aeoi_pend_s;
  logic                 aeoi_clr_r;
  logic [VECTOR_W-1:0]  dout_r, dout_s;
  logic                 doe_r, doe_s;
  logic                 spurious_r, spurious_s;
  logic                 respond_r, respond_s;
  logic                 respond_now_s;
  logic [15:0]          cnt_r, cnt_s;

  // Whether this device answers the second pulse with its vector
  always_comb begin
    respond_now_s = 1'b0;
    if (SNGL) begin
      respond_now_s = 1'b1;
    end else if (Master_Slave) begin
      respond_now_s = ~SLAVE_MASK[isr_r];
    end else begin
      respond_now_s = (ID == SLAVE_ID);
    end
  end

  // Handshake next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    int_s       = 1'b0;
    inta2_s     = inta2_r;
    isr_s       = isr_r;
    isr_set_s   = 1'b0;
    aeoi_pend_s = 1'b0;
    dout_s      = dout_r;
    doe_s       = doe_r;
    spurious_s  = spurious_r;
    respond_s   = respond_r;
    cnt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        int_s = INT_PENDING;
        if (fall_s) begin
          state_s   = ACK1;
          int_s     = 1'b0;
          inta2_s   = 1'b1;
          respond_s = 1'b0;
          if (INT_PENDING) begin
            isr_s      = INT_LEVEL;
            spurious_s = 1'b0;
            isr_set_s  = Master_Slave | SNGL;
          end else begin
            isr_s      = SPURIOUS_LEVEL;
            spurious_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACK1: begin
        if (rise_s) begin
          state_s = GAP;
          cnt_s   = 16'd0;
        end else begin
          state_s = ACK1;
        end
      end
      GAP: begin
        if (fall_s) begin
          state_s   = ACK2;
          respond_s = respond_now_s;
          doe_s     = respond_now_s;
          dout_s    = make_vector(VECTOR_BASE, isr_r);
          // A slave only marks in-service once the master has selected it
          isr_set_s = ~SNGL & ~Master_Slave & respond_now_s & ~spurious_r;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
          inta2_s = 1'b0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ACK2: begin
        if (rise_s) begin
          state_s     = IDLE;
          doe_s       = 1'b0;
          inta2_s     = 1'b0;
          aeoi_pend_s = AEOI & ~spurious_r & (SNGL | Master_Slave | respond_r);
        end else begin
          state_s = ACK2;
        end
      end
      default: begin
        state_s = IDLE;
        inta2_s = 1'b0;
        doe_s   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; AEOI clear lands one cycle after the handshake closes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      int_r       <= 1'b0;
      inta2_r     <= 1'b0;
      isr_r       <= 3'd0;
      isr_set_r   <= 1'b0;
      aeoi_pend_r <= 1'b0;
      aeoi_clr_r  <= 1'b0;
      dout_r      <= 8'd0;
      doe_r       <= 1'b0;
      spurious_r  <= 1'b0;
      respond_r   <= 1'b0;
      cnt_r       <= 16'd0;
    end else begin
      state_r     <= state_s;
      int_r       <= int_s;
      inta2_r     <= inta2_s;
      isr_r       <= isr_s;
      isr_set_r   <= isr_set_s;
      aeoi_pend_r <= aeoi_pend_s;
      aeoi_clr_r  <= aeoi_pend_r;
      dout_r      <= dout_s;
      doe_r       <= doe_s;
      spurious_r  <= spurious_s;
      respond_r   <= respond_s;
      cnt_r       <= cnt_s;
    end
  end

  assign INT      = int_r;
  assign INTA_2   = inta2_r;
  assign ISR      = isr_r;
  assign ISR_SET  = isr_set_r;
  assign AEOI_CLR = aeoi_clr_r;
  assign D_OUT    = dout_r;
  assign D_OE     = doe_r;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: single, master, slave, spurious, AEOI,
// timeout and mid-handshake reset scenarios with hand-computed expectations.
module tb_inta_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       INTA_N = 1'b1;
  logic       SNGL = 1'b1;
  logic       Master_Slave = 1'b1;
  logic [2:0] ID = 3'd0;
  logic [2:0] SLAVE_ID = 3'd0;
  logic [7:0] SLAVE_MASK = 8'h00;
  logic       AEOI = 1'b0;
  logic [4:0] VECTOR_BASE = 5'b01000;
  logic       INT_PENDING = 1'b0;
  logic [2:0] INT_LEVEL = 3'd0;
  logic       INT, INTA_2, ISR_SET, AEOI_CLR, D_OE;
  logic [2:0] ISR;
  logic [7:0] D_OUT;

  int checks = 0;
  int errors = 0;

  inta_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .INTA_N(INTA_N), .SNGL(SNGL), .Master_Slave(Master_Slave),
    .ID(ID), .SLAVE_ID(SLAVE_ID), .SLAVE_MASK(SLAVE_MASK), .AEOI(AEOI),
    .VECTOR_BASE(VECTOR_BASE), .INT_PENDING(INT_PENDING), .INT_LEVEL(INT_LEVEL),
    .INT(INT), .INTA_2(INTA_2), .ISR(ISR), .ISR_SET(ISR_SET), .AEOI_CLR(AEOI_CLR),
    .D_OUT(D_OUT), .D_OE(D_OE)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full two-pulse acknowledge with checks at each reaction point
  task automatic ack(input string tag, input logic [2:0] exp_isr, input logic exp_set1,
                     input logic exp_set2, input logic exp_oe, input logic [7:0] exp_dout,
                     input logic exp_aeoi);
    INTA_N = 1'b0;
    tick(2);
    chk({tag, " latency inta2"}, {7'd0, INTA_2}, 8'd0);
    tick(1);
    chk({tag, " inta2 set"}, {7'd0, INTA_2}, 8'd1);
    chk({tag, " int dropped"}, {7'd0, INT}, 8'd0);
    chk({tag, " isr"}, {5'd0, ISR}, {5'd0, exp_isr});
    chk({tag, " isr_set 1st"}, {7'd0, ISR_SET}, {7'd0, exp_set1});
    tick(1);
    chk({tag, " isr_set 1st end"}, {7'd0, ISR_SET}, 8'd0);
    INTA_N = 1'b1;
    tick(3);
    chk({tag, " d_oe gap"}, {7'd0, D_OE}, 8'd0);
    tick(1);
    INTA_N = 1'b0;
    tick(3);
    chk({tag, " d_oe"}, {7'd0, D_OE}, {7'd0, exp_oe});
    chk({tag, " d_out"}, D_OUT, exp_dout);
    chk({tag, " isr_set 2nd"}, {7'd0, ISR_SET}, {7'd0, exp_set2});
    chk({tag, " int held"}, {7'd0, INT}, 8'd0);
    tick(1);
    chk({tag, " isr_set 2nd end"}, {7'd0, ISR_SET}, 8'd0);
    INTA_N = 1'b1;
    tick(3);
    chk({tag, " inta2 clr"}, {7'd0, INTA_2}, 8'd0);
    chk({tag, " d_oe clr"}, {7'd0, D_OE}, 8'd0);
    chk({tag, " aeoi early"}, {7'd0, AEOI_CLR}, 8'd0);
    tick(1);
    chk({tag, " aeoi_clr"}, {7'd0, AEOI_CLR}, {7'd0, exp_aeoi});
    chk({tag, " int back"}, {7'd0, INT}, {7'd0, INT_PENDING});
    tick(1);
    chk({tag, " aeoi_clr end"}, {7'd0, AEOI_CLR}, 8'd0);
    tick(2);
  endtask

  initial begin
    // Reset state
    INT_PENDING = 1'b1;
    INT_LEVEL   = 3'd3;
    tick(2);
    chk("rst int", {7'd0, INT}, 8'd0);
    chk("rst inta2", {7'd0, INTA_2}, 8'd0);
    chk("rst d_oe", {7'd0, D_OE}, 8'd0);
    chk("rst d_out", D_OUT, 8'h00);
    chk("rst isr", {5'd0, ISR}, 8'd0);
    RST_N = 1'b1;
    tick(2);
    chk("idle int", {7'd0, INT}, 8'd1);

    // Single mode, level 3, base 0x08 -> vector 0x43
    ack("single", 3'd3, 1'b1, 1'b0, 1'b1, 8'h43, 1'b0);

    // Master cascade: level 3 has a slave, so master stays off the bus
    SNGL = 1'b0; Master_Slave = 1'b1; SLAVE_MASK = 8'h08;
    ack("master slaved", 3'd3, 1'b1, 1'b0, 1'b0, 8'h43, 1'b0);
    INT_LEVEL = 3'd2;
    ack("master own", 3'd2, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0);

    // Slave: selected by ID match only
    Master_Slave = 1'b0; SLAVE_ID = 3'd4; ID = 3'd4; INT_LEVEL = 3'd5;
    ack("slave hit", 3'd5, 1'b0, 1'b1, 1'b1, 8'h45, 1'b0);
    ID = 3'd5;
    ack("slave miss", 3'd5, 1'b0, 1'b0, 1'b0, 8'h45, 1'b0);

    // Spurious: request withdrawn before first pulse, AEOI must not fire
    SNGL = 1'b1; Master_Slave = 1'b1; AEOI = 1'b1; INT_PENDING = 1'b0;
    tick(2);
    chk("spur int low", {7'd0, INT}, 8'd0);
    ack("spurious", 3'd7, 1'b0, 1'b0, 1'b1, 8'h47, 1'b0);

    // AEOI single-mode level 6
    INT_PENDING = 1'b1; INT_LEVEL = 3'd6;
    tick(2);
    ack("aeoi", 3'd6, 1'b1, 1'b0, 1'b1, 8'h46, 1'b1);

    // Timeout: 16 GAP cycles without a second pulse
    INTA_N = 1'b0;
    tick(3);
    chk("to inta2 set", {7'd0, INTA_2}, 8'd1);
    INTA_N = 1'b1;
    tick(3);
    tick(15);
    chk("to inta2 before", {7'd0, INTA_2}, 8'd1);
    tick(1);
    chk("to inta2 clr", {7'd0, INTA_2}, 8'd0);
    chk("to int still low", {7'd0, INT}, 8'd0);
    tick(1);
    chk("to int follows", {7'd0, INT}, 8'd1);
    chk("to no aeoi", {7'd0, AEOI_CLR}, 8'd0);
    INT_PENDING = 1'b0;
    tick(1);
    chk("to int follows low", {7'd0, INT}, 8'd0);
    INT_PENDING = 1'b1;
    tick(2);

    // Reset while in ACK2 with the bus driven
    INTA_N = 1'b0; tick(3);
    INTA_N = 1'b1; tick(4);
    INTA_N = 1'b0; tick(3);
    chk("ack2 d_oe", {7'd0, D_OE}, 8'd1);
    RST_N = 1'b0;
    #1;
    chk("rst2 d_oe", {7'd0, D_OE}, 8'd0);
    chk("rst2 inta2", {7'd0, INTA_2}, 8'd0);
    chk("rst2 d_out", D_OUT, 8'h00);
    chk("rst2 isr", {5'd0, ISR}, 8'd0);
    chk("rst2 int", {7'd0, INT}, 8'd0);
    INTA_N = 1'b1;
    tick(2);
    RST_N = 1'b1;
    tick(4);
    chk("post rst inta2", {7'd0, INTA_2}, 8'd0);
    chk("post rst aeoi", {7'd0, AEOI_CLR}, 8'd0);
    chk("post rst int", {7'd0, INT}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
